// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 SCCB configuration sequencer.
package ov7670_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    BITS,
    STOP,
    GAP,
    DELAY,
    DONE
  } state_t;

  // Table markers: an entry with these values is never sent to the sensor.
  localparam logic [15:0] END_MARK     = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK   = 16'hFFF0;

  // OV7670 write address (7-bit id 0x21 plus the write bit).
  localparam logic [7:0]  SCCB_WR_ADDR = 8'h42;

  // Three bytes, each 8 data bits followed by one don't-care slot.
  localparam int          BITS_PER_TXN = 27;

  // Highest table index; the walk stops here even without an end marker.
  localparam logic [7:0]  LAST_INDEX   = 8'hFF;

  // True for the ninth slot of each byte, where the camera may drive an ACK.
  function automatic logic is_dc_slot(input logic [4:0] slot);
    return (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
  endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Power-up register table for the OV7670: RGB565 output at QVGA resolution.
// Each entry is {register address, value}; markers are defined in the package.
module ov7670_reg_rom
  import ov7670_cfg_pkg::*;
(
  input  logic [7:0]  idx,
  output logic [15:0] entry
);

  // Table lookup; anything past the last entry reads as the end marker.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    entry = END_MARK;
    case (idx)
      8'd0:  entry = 16'h1280;    // COM7: soft reset of all registers
      8'd1:  entry = DELAY_MARK;  // let the sensor settle after the reset
      8'd2:  entry = 16'h1214;    // COM7: QVGA, RGB output
      8'd3:  entry = 16'h40D0;    // COM15: full range, RGB565
      8'd4:  entry = 16'h8C00;    // RGB444: disabled
      8'd5:  entry = 16'h1101;    // CLKRC: internal clock prescaler
      8'd6:  entry = 16'h0C04;    // COM3: enable downsample/crop
      8'd7:  entry = 16'h3E19;    // COM14: PCLK divider for QVGA
      8'd8:  entry = 16'h7211;    // SCALING_DCWCTR
      8'd9:  entry = 16'h73F1;    // SCALING_PCLK_DIV
      8'd10: entry = 16'h1716;    // HSTART
      8'd11: entry = 16'h1804;    // HSTOP
      8'd12: entry = 16'h32A4;    // HREF edge offsets
      8'd13: entry = 16'h1902;    // VSTART
      8'd14: entry = 16'h1A7A;    // VSTOP
      8'd15: entry = 16'h030A;    // VREF edge offsets
      8'd16: entry = 16'h3A04;    // TSLB: output byte order
      8'd17: entry = 16'h3DC8;    // COM13: gamma and UV saturation
      8'd18: entry = 16'h1500;    // COM10: default sync polarities
      8'd19: entry = END_MARK;
      default: entry = END_MARK;
    endcase
  end

endmodule

// File: rtl/ov7670_sccb_config.sv
// OV7670 configuration sequencer: walks the register table and sends each
// entry as an SCCB 3-phase write (device address, register, value).
// Line levels are registered so sioc/siod never glitch between quarters.
module ov7670_sccb_config
  import ov7670_cfg_pkg::*;
#(
  parameter int SYS_CLK_HZ   = 100_000_000,
  parameter int SCCB_HZ      = 100_000,
  parameter int DELAY_CYCLES = 1_000_000,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] reg_index,
  output logic       sioc,
  output logic       siod_out,
  output logic       siod_oe
);

  // Quarter-bit period in system clocks; must be at least 2.
  localparam int TICK_DIV = SYS_CLK_HZ / (4 * SCCB_HZ);
  localparam int QW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW       = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  state_t          state, state_nx;
  logic [QW-1:0]   qcnt;
  logic [1:0]      phase;
  logic [4:0]      slot;
  logic [23:0]     shreg;
  logic [DW-1:0]   delay_cnt;
  logic            auto_pending;
  logic [15:0]     entry;
  logic            tick, last_q, quarter_run, start_ok, delay_end;
  logic            sioc_nx, siod_nx, oe_nx;

  ov7670_reg_rom u_rom (
    .idx   (reg_index),
    .entry (entry)
  );

  assign tick        = (qcnt == QW'(TICK_DIV - 1));
  assign last_q      = tick && (phase == 2'd3);
  assign quarter_run = state inside {START, BITS, STOP, GAP};
  assign start_ok    = (start || auto_pending) && ((state == IDLE) || (state == DONE));
  assign delay_end   = (delay_cnt == DW'(DELAY_CYCLES - 1));
  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode: one quarter-bit phase cycle per START/STOP/GAP, 27 in BITS.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start_ok) state_nx = LOAD;
      LOAD: begin
        if ((entry == END_MARK) || (reg_index == LAST_INDEX)) state_nx = DONE;
        else if (entry == DELAY_MARK)                          state_nx = DELAY;
        else                                                   state_nx = START;
      end
      START: if (last_q) state_nx = BITS;
      BITS:  if (last_q && (slot == 5'(BITS_PER_TXN - 1))) state_nx = STOP;
      STOP:  if (last_q) state_nx = GAP;
      GAP:   if (last_q) state_nx = LOAD;
      DELAY: if (delay_end) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // Line levels for the current quarter; everything outside a frame idles high.
  always_comb begin
    sioc_nx = 1'b1;
    siod_nx = 1'b1;
    oe_nx   = 1'b1;
    case (state)
      START: begin
        sioc_nx = ~phase[1];
        siod_nx = (phase == 2'd0);
      end
      BITS: begin
        sioc_nx = (phase == 2'd1) || (phase == 2'd2);
        if (is_dc_slot(slot)) oe_nx   = 1'b0;
        else                  siod_nx = shreg[23];
      end
      STOP: begin
        sioc_nx = (phase != 2'd0);
        siod_nx = phase[1];
      end
      default: ;
    endcase
  end

  // Divider, bit/slot counters, shift register, table index and registered pads.
  always_ff @(posedge clk) begin
    if (reset) begin
      qcnt         <= '0;
      phase        <= 2'd0;
      slot         <= 5'd0;
      shreg        <= '0;
      delay_cnt    <= '0;
      reg_index    <= 8'd0;
      auto_pending <= AUTO_START;
      sioc         <= 1'b1;
      siod_out     <= 1'b1;
      siod_oe      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      auto_pending <= 1'b0;
      sioc         <= sioc_nx;
      siod_out     <= siod_nx;
      siod_oe      <= oe_nx;

      // Quarter divider only runs inside a frame; LOAD re-aligns it for START.
      if (quarter_run) begin
        if (tick) begin
          qcnt  <= '0;
          phase <= phase + 2'd1;
        end else begin
          qcnt  <= qcnt + QW'(1);
        end
      end else begin
        qcnt  <= '0;
        phase <= 2'd0;
      end

      if (state == LOAD) begin
        shreg <= {SCCB_WR_ADDR, entry};
        slot  <= 5'd0;
      end else if ((state == BITS) && last_q) begin
        slot <= slot + 5'd1;
        if (!is_dc_slot(slot)) shreg <= {shreg[22:0], 1'b0};
      end

      if (state == DELAY) delay_cnt <= delay_cnt + DW'(1);
      else                delay_cnt <= '0;

      if (start_ok)
        reg_index <= 8'd0;
      else if (((state == GAP) && last_q) || ((state == DELAY) && delay_end))
        reg_index <= reg_index + 8'd1;
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Self-checking bench for ov7670_sccb_config: decodes the SCCB line activity
// into transactions and compares them with a table-driven reference model.
module tb_ov7670_sccb_config;

  localparam int SYS_CLK_HZ   = 800;
  localparam int SCCB_HZ      = 100;
  localparam int DELAY_CYCLES = 20;
  localparam int TICK_DIV     = SYS_CLK_HZ / (4 * SCCB_HZ);
  // A frame spans 116 quarters; START q0 and STOP q2/q3 look like idle lines,
  // so the visible START-to-STOP span is 3 quarters shorter.
  localparam int TXN_CYCLES   = 116 * TICK_DIV;
  localparam int COND_SPAN    = TXN_CYCLES - 3 * TICK_DIV;
  // STOP tail (2q) + GAP (4q) + LOAD (1 cycle) + START q0 (1q).
  localparam int BASE_GAP     = 2 * TICK_DIV + 4 * TICK_DIV + 1 + TICK_DIV;
  localparam logic [26:0] OE_EXP = {3{9'b1_1111_1110}};
  localparam int TABLE_LEN    = 20;
  localparam logic [15:0] TB_TABLE [TABLE_LEN] = '{
    16'h1280, 16'hFFF0, 16'h1214, 16'h40D0, 16'h8C00, 16'h1101, 16'h0C04,
    16'h3E19, 16'h7211, 16'h73F1, 16'h1716, 16'h1804, 16'h32A4, 16'h1902,
    16'h1A7A, 16'h030A, 16'h3A04, 16'h3DC8, 16'h1500, 16'hFFFF};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, sioc, siod_out, siod_oe;
  logic [7:0] reg_index;

  always #5 clk = ~clk;

  ov7670_sccb_config #(
    .SYS_CLK_HZ   (SYS_CLK_HZ),
    .SCCB_HZ      (SCCB_HZ),
    .DELAY_CYCLES (DELAY_CYCLES),
    .AUTO_START   (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .reg_index (reg_index),
    .sioc      (sioc),
    .siod_out  (siod_out),
    .siod_oe   (siod_oe)
  );

  typedef struct {
    int          pulses;
    logic [26:0] bits;
    logic [26:0] oe;
    int          t_start;
    int          t_stop;
    int          idle_before;
  } txn_t;

  typedef struct {
    logic [15:0] entry;
    int          gap;
  } exp_t;

  txn_t txq[$];
  exp_t model[$];
  int   end_index;
  int   last_stop;
  int   checks = 0;
  int   errors = 0;

  // Pad model: the bench pulls the line low whenever the DUT releases it.
  logic sda;
  assign sda = siod_oe ? siod_out : 1'b0;

  logic        p_sioc = 1'b1, p_sda = 1'b1, hi = 1'b0, in_txn = 1'b0;
  logic        rise_bit = 1'b0, rise_oe = 1'b0;
  logic [26:0] sh_bits = '0, sh_oe = '0;
  int          cyc = 0, cur_pulses = 0, t_start_m = 0, idle_run = 0, idle_at_start = 0;

  // SCCB monitor: START/STOP detection and bit capture on completed sioc pulses.
  always @(negedge clk) begin
    txn_t r;
    cyc++;
    if (p_sioc && sioc && p_sda && !sda) begin
      in_txn = 1'b1; hi = 1'b0; cur_pulses = 0; sh_bits = '0; sh_oe = '0;
      t_start_m = cyc; idle_at_start = idle_run;
    end else if (p_sioc && sioc && !p_sda && sda && in_txn) begin
      r.pulses = cur_pulses; r.bits = sh_bits; r.oe = sh_oe;
      r.t_start = t_start_m; r.t_stop = cyc; r.idle_before = idle_at_start;
      txq.push_back(r);
      in_txn = 1'b0;
    end else if (in_txn) begin
      if (!p_sioc && sioc) begin
        hi = 1'b1; rise_bit = sda; rise_oe = siod_oe;
      end else if (p_sioc && !sioc && hi) begin
        hi = 1'b0; cur_pulses++;
        sh_bits = {sh_bits[25:0], rise_bit};
        sh_oe   = {sh_oe[25:0], rise_oe};
      end
    end
    if (sioc && sda) idle_run++;
    else             idle_run = 0;
    p_sioc = sioc;
    p_sda  = sda;
  end

  // Expected write stream: every non-marker entry in order, with the idle gap
  // that precedes it (each delay marker adds its wait plus one table read).
  task automatic build_model();
    exp_t e;
    int   delays = 0;
    model.delete();
    end_index = TABLE_LEN - 1;
    for (int i = 0; i < TABLE_LEN; i++) begin
      if (TB_TABLE[i] == 16'hFFFF) begin
        end_index = i;
        break;
      end
      if (TB_TABLE[i] == 16'hFFF0) begin
        delays++;
      end else begin
        e.entry = TB_TABLE[i];
        e.gap   = BASE_GAP + delays * (DELAY_CYCLES + 1);
        model.push_back(e);
        delays = 0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({sioc, siod_out, siod_oe, busy, done} !== 5'b11100) begin
      $display("FAIL reset_lines: got sioc/siod/oe/busy/done=%b expected 11100",
               {sioc, siod_out, siod_oe, busy, done});
      errors++;
    end
    checks++;
    if (reg_index !== 8'd0) begin
      $display("FAIL reset_index: got %0d expected 0", reg_index);
      errors++;
    end
    txq.delete();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL auto_start: got busy=%b done=%b expected busy=1 done=0", busy, done);
      errors++;
    end
  endtask

  task automatic test_first_txn();
    txn_t        r;
    logic [23:0] bytes;
    int          n;
    for (n = 0; n < 2000 && txq.size() == 0; n++) @(negedge clk);
    checks++;
    if (txq.size() == 0) begin
      $display("FAIL first_txn_timeout: got no transaction expected one within 2000 cycles");
      errors++;
      return;
    end
    r = txq.pop_front();
    last_stop = r.t_stop;
    bytes = {r.bits[26:19], r.bits[17:10], r.bits[8:1]};
    checks++;
    if (bytes !== 24'h421280) begin
      $display("FAIL first_bytes: got %06h expected 421280", bytes);
      errors++;
    end
    checks++;
    if (r.pulses !== 27) begin
      $display("FAIL first_pulses: got %0d expected 27", r.pulses);
      errors++;
    end
    checks++;
    if (r.t_stop - r.t_start + 3 * TICK_DIV !== TXN_CYCLES) begin
      $display("FAIL first_duration: got %0d expected %0d",
               r.t_stop - r.t_start + 3 * TICK_DIV, TXN_CYCLES);
      errors++;
    end
    checks++;
    if (r.oe !== OE_EXP) begin
      $display("FAIL first_oe_slots: got %b expected %b", r.oe, OE_EXP);
      errors++;
    end
  endtask

  task automatic test_delay_marker();
    txn_t        r;
    logic [23:0] bytes;
    int          n;
    for (n = 0; n < 2000 && txq.size() == 0; n++) @(negedge clk);
    checks++;
    if (txq.size() == 0) begin
      $display("FAIL delay_timeout: got no transaction expected one within 2000 cycles");
      errors++;
      return;
    end
    r = txq.pop_front();
    bytes = {r.bits[26:19], r.bits[17:10], r.bits[8:1]};
    checks++;
    if (bytes !== {8'h42, model[1].entry}) begin
      $display("FAIL delay_next_bytes: got %06h expected 42%04h", bytes, model[1].entry);
      errors++;
    end
    checks++;
    if (r.idle_before !== model[1].gap || r.idle_before < DELAY_CYCLES) begin
      $display("FAIL delay_idle_high: got %0d idle cycles expected %0d", r.idle_before, model[1].gap);
      errors++;
    end
    last_stop = r.t_stop;
  endtask

  task automatic test_full_table(input int first, input bit fresh);
    txn_t        r;
    exp_t        m;
    logic [23:0] bytes;
    logic        prev_busy;
    bit          seen;
    prev_busy = busy;
    seen = 0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      prev_busy = busy;
    end
    checks++;
    if (!seen) begin
      $display("FAIL done_timeout: got done=%b expected 1 within 20000 cycles", done);
      errors++;
      return;
    end
    checks++;
    if (busy !== 1'b0 || prev_busy !== 1'b1 || reg_index !== 8'(end_index)) begin
      $display("FAIL done_entry: got busy=%b prev_busy=%b index=%0d expected 0/1/%0d",
               busy, prev_busy, reg_index, end_index);
      errors++;
    end
    checks++;
    if (txq.size() !== model.size() - first) begin
      $display("FAIL table_count: got %0d transactions expected %0d", txq.size(), model.size() - first);
      errors++;
    end
    for (int i = 0; i < txq.size() && first + i < model.size(); i++) begin
      r = txq[i];
      m = model[first + i];
      bytes = {r.bits[26:19], r.bits[17:10], r.bits[8:1]};
      checks++;
      if (bytes !== {8'h42, m.entry} || r.pulses !== 27 || r.oe !== OE_EXP ||
          r.t_stop - r.t_start !== COND_SPAN) begin
        $display("FAIL table_txn%0d: got bytes=%06h pulses=%0d oe=%b span=%0d expected 42%04h/27/%b/%0d",
                 first + i, bytes, r.pulses, r.oe, r.t_stop - r.t_start, m.entry, OE_EXP, COND_SPAN);
        errors++;
      end
      if (i > 0 || !fresh) begin
        checks++;
        if (r.t_start - last_stop !== m.gap) begin
          $display("FAIL table_gap%0d: got %0d expected %0d", first + i, r.t_start - last_stop, m.gap);
          errors++;
        end
      end
      last_stop = r.t_stop;
    end
    txq.delete();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({sioc, siod_out, siod_oe, done, busy} !== 5'b11110) begin
        $display("FAIL done_idle: got sioc/siod/oe/done/busy=%b expected 11110",
                 {sioc, siod_out, siod_oe, done, busy});
        errors++;
      end
    end
  endtask

  task automatic test_start_in_done();
    repeat ($urandom_range(1, 30)) @(negedge clk);
    txq.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || reg_index !== 8'd0) begin
      $display("FAIL restart_from_done: got busy=%b done=%b index=%0d expected 1/0/0",
               busy, done, reg_index);
      errors++;
    end
  endtask

  task automatic test_start_while_busy();
    int   k;
    int   n;
    logic [7:0] idx_before;
    k = $urandom_range(2, 5);
    for (n = 0; n < 5000 && txq.size() < k; n++) @(negedge clk);
    checks++;
    if (txq.size() < k) begin
      $display("FAIL busy_start_timeout: got %0d transactions expected %0d", txq.size(), k);
      errors++;
      return;
    end
    repeat ($urandom_range(20, 200)) @(negedge clk);
    idx_before = reg_index;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (reg_index !== idx_before || busy !== 1'b1) begin
      $display("FAIL start_while_busy: got index=%0d busy=%b expected index=%0d busy=1",
               reg_index, busy, idx_before);
      errors++;
    end
  endtask

  task automatic test_reset_abort();
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (n = 0; n < 3000 && txq.size() < 2; n++) @(negedge clk);
    for (n = 0; n < 3000 && !(in_txn && cur_pulses == 11); n++) @(negedge clk);
    checks++;
    if (!(in_txn && cur_pulses == 11)) begin
      $display("FAIL abort_setup_timeout: got pulses=%0d expected 11", cur_pulses);
      errors++;
    end
    repeat (2 + $urandom_range(0, 6)) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({sioc, siod_out, siod_oe, busy, done} !== 5'b11100 || reg_index !== 8'd0) begin
      $display("FAIL abort_lines: got sioc/siod/oe/busy/done=%b index=%0d expected 11100 index=0",
               {sioc, siod_out, siod_oe, busy, done}, reg_index);
      errors++;
    end
    @(negedge clk);
    txq.delete();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || reg_index !== 8'd0) begin
      $display("FAIL abort_restart: got busy=%b index=%0d expected busy=1 index=0", busy, reg_index);
      errors++;
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_first_txn();
    test_delay_marker();
    test_full_table(2, 1'b0);
    test_start_in_done();
    test_start_while_busy();
    test_full_table(0, 1'b1);
    test_reset_abort();
    test_first_txn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
